// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one external 4x3 pipelined multiplier among NREQ requesters.
// A tag pipe tracks each in-flight product; a credit-limited FIFO returns results in grant order.
module mul_share_arbiter #(
   parameter int NREQ      = 2,
   parameter int MUL_LAT   = 2,
   parameter int RSP_DEPTH = 4,
   parameter int ID_W      = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NREQ-1:0]     i_req_valid,
   output logic [NREQ-1:0]     o_req_ready,
   input  logic [4*NREQ-1:0]   i_req_a,
   input  logic [3*NREQ-1:0]   i_req_b,
   output logic [3:0]          o_mul_a,
   output logic [2:0]          o_mul_b,
   input  logic [7:0]          i_mul_y,
   output logic                o_rsp_valid,
   input  logic                i_rsp_ready,
   output logic [ID_W-1:0]     o_rsp_id,
   output logic [7:0]          o_rsp_y
);

   localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int CNT_W = $clog2(RSP_DEPTH + MUL_LAT + 1);

   logic                r_run;
   logic [ID_W-1:0]     r_rr_ptr;
   logic [MUL_LAT-1:0]  r_tag_vld;
   logic [ID_W-1:0]     r_tag_id [MUL_LAT];
   logic [7:0]          r_mem_y  [RSP_DEPTH];
   logic [ID_W-1:0]     r_mem_id [RSP_DEPTH];
   logic [PTR_W-1:0]    r_wr_ptr;
   logic [PTR_W-1:0]    r_rd_ptr;
   logic [CNT_W-1:0]    r_count;

   logic [CNT_W-1:0]    w_inflight;
   logic                w_credit;
   logic                w_found;
   logic [ID_W-1:0]     w_gnt;
   logic [ID_W-1:0]     w_nxt_rr;
   logic                w_accept;
   logic                w_push;
   logic                w_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      w_inflight = '0;
      for (int i = 0; i < MUL_LAT; i++) begin
         w_inflight = w_inflight + CNT_W'(r_tag_vld[i]);
      end
   end

   // Registered occupancy only: a pop in this cycle does not free a slot until next cycle.
   assign w_credit = (r_count + w_inflight) < CNT_W'(RSP_DEPTH);

   // Two passes: indices at or above rr_ptr first, then the wrapped-around low indices.
   always_comb begin
      w_found = 1'b0;
      w_gnt   = '0;
      for (int j = 0; j < NREQ; j++) begin
         if (!w_found && i_req_valid[j] && (ID_W'(j) >= r_rr_ptr)) begin
            w_found = 1'b1;
            w_gnt   = ID_W'(j);
         end
      end
      for (int j = 0; j < NREQ; j++) begin
         if (!w_found && i_req_valid[j]) begin
            w_found = 1'b1;
            w_gnt   = ID_W'(j);
         end
      end
   end

   assign w_accept = r_run & w_found & w_credit;
   assign w_nxt_rr = (w_gnt == ID_W'(NREQ - 1)) ? '0 : w_gnt + 1'b1;

   always_comb begin
      o_req_ready = '0;
      o_mul_a     = '0;
      o_mul_b     = '0;
      for (int j = 0; j < NREQ; j++) begin
         if (w_accept && (w_gnt == ID_W'(j))) begin
            o_req_ready[j] = 1'b1;
            o_mul_a        = i_req_a[4*j +: 4];
            o_mul_b        = i_req_b[3*j +: 3];
         end
      end
   end

   assign w_push      = r_tag_vld[MUL_LAT-1];
   assign o_rsp_valid = (r_count != '0);
   assign w_pop       = o_rsp_valid & i_rsp_ready;
   assign o_rsp_id    = r_mem_id[r_rd_ptr];
   assign o_rsp_y     = r_mem_y[r_rd_ptr];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_run     <= 1'b0;
         r_rr_ptr  <= '0;
         r_tag_vld <= '0;
         for (int i = 0; i < MUL_LAT; i++) begin
            r_tag_id[i] <= '0;
         end
         for (int i = 0; i < RSP_DEPTH; i++) begin
            r_mem_y[i]  <= '0;
            r_mem_id[i] <= '0;
         end
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
      end else begin
         r_run <= 1'b1;
         if (w_accept) begin
            r_rr_ptr <= w_nxt_rr;
         end
         r_tag_vld[0] <= w_accept;
         r_tag_id[0]  <= w_accept ? w_gnt : '0;
         for (int i = 1; i < MUL_LAT; i++) begin
            r_tag_vld[i] <= r_tag_vld[i-1];
            r_tag_id[i]  <= r_tag_id[i-1];
         end
         if (w_push) begin
            r_mem_y[r_wr_ptr]  <= i_mul_y;
            r_mem_id[r_wr_ptr] <= r_tag_id[MUL_LAT-1];
            r_wr_ptr           <= ptr_inc(r_wr_ptr);
         end
         if (w_pop) begin
            r_rd_ptr <= ptr_inc(r_rd_ptr);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter: a 2-requester instance plus a 3-requester instance,
// each driving a behavioural two-stage multiplier.
module tb_mul_share_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;

   logic [1:0]  req_valid = '0;
   logic [1:0]  req_ready;
   logic [7:0]  req_a = '0;
   logic [5:0]  req_b = '0;
   logic [3:0]  mul_a;
   logic [2:0]  mul_b;
   logic [7:0]  mul_y;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [0:0]  rsp_id;
   logic [7:0]  rsp_y;

   logic [2:0]  t_valid = '0;
   logic [2:0]  t_ready;
   logic [11:0] t_a = '0;
   logic [8:0]  t_b = '0;
   logic [3:0]  t_mul_a;
   logic [2:0]  t_mul_b;
   logic [7:0]  t_mul_y;
   logic        t_rsp_valid;
   logic        t_rsp_ready = 1'b1;
   logic [1:0]  t_rsp_id;
   logic [7:0]  t_rsp_y;

   logic [7:0]  m2_p0, m2_y, m3_p0, m3_y;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   mul_share_arbiter #(.NREQ(2), .MUL_LAT(2), .RSP_DEPTH(4), .ID_W(1)) u_dut (
      .clk(clk), .rst(rst),
      .i_req_valid(req_valid), .o_req_ready(req_ready),
      .i_req_a(req_a), .i_req_b(req_b),
      .o_mul_a(mul_a), .o_mul_b(mul_b), .i_mul_y(mul_y),
      .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
      .o_rsp_id(rsp_id), .o_rsp_y(rsp_y)
   );

   mul_share_arbiter #(.NREQ(3), .MUL_LAT(2), .RSP_DEPTH(4), .ID_W(2)) u_dut3 (
      .clk(clk), .rst(rst),
      .i_req_valid(t_valid), .o_req_ready(t_ready),
      .i_req_a(t_a), .i_req_b(t_b),
      .o_mul_a(t_mul_a), .o_mul_b(t_mul_b), .i_mul_y(t_mul_y),
      .o_rsp_valid(t_rsp_valid), .i_rsp_ready(t_rsp_ready),
      .o_rsp_id(t_rsp_id), .o_rsp_y(t_rsp_y)
   );

   // Operands sampled at edge E0, product visible after E0+1.
   always @(posedge clk) begin
      m2_p0 <= {4'b0, mul_a} * {5'b0, mul_b};
      m2_y  <= m2_p0;
      m3_p0 <= {4'b0, t_mul_a} * {5'b0, t_mul_b};
      m3_y  <= m3_p0;
   end
   assign mul_y   = m2_y;
   assign t_mul_y = m3_y;

   typedef struct {
      int req;
      int a;
      int b;
      int exp_y;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic set_op(input int r, input int a, input int b);
      req_a[4*r +: 4] = 4'(a);
      req_b[3*r +: 3] = 3'(b);
   endtask

   task automatic set_op3(input int r, input int a, input int b);
      t_a[4*r +: 4] = 4'(a);
      t_b[3*r +: 3] = 3'(b);
   endtask

   task automatic single_op(input int r, input int a, input int b, input int exp_y);
      int lat;
      @(posedge clk); #1;
      req_valid    = '0;
      req_valid[r] = 1'b1;
      set_op(r, a, b);
      @(negedge clk);
      check("vec_ready", int'(req_ready), 1 << r);
      @(posedge clk); #1;
      req_valid = '0;
      lat = 1;
      @(negedge clk);
      while (!rsp_valid && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      check("vec_latency", lat, 3);
      check("vec_id", int'(rsp_id), r);
      check("vec_y", int'(rsp_y), exp_y);
      @(negedge clk);
      check("vec_pulse", int'(rsp_valid), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   initial begin
      int cnt;
      int gseq [10];
      gseq = '{0, 1, 2, 0, 1, 2, 0, 2, 0, 2};

      vecs[0] = '{0, 7, 5, 35};
      vecs[1] = '{0, 0, 7, 0};
      vecs[2] = '{0, 15, 0, 0};
      vecs[3] = '{0, 15, 7, 105};
      vecs[4] = '{1, 15, 7, 105};
      vecs[5] = '{0, 1, 1, 1};
      vecs[6] = '{1, 3, 2, 6};

      // reset state, with requests offered while held in reset
      req_valid = 2'b11;
      set_op(0, 5, 5);
      #12;
      check("rst_ready", int'(req_ready), 0);
      check("rst_rsp_valid", int'(rsp_valid), 0);
      check("rst_rsp_id", int'(rsp_id), 0);
      check("rst_rsp_y", int'(rsp_y), 0);
      req_valid = '0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // single operations, including edge operands
      rsp_ready = 1'b1;
      for (int v = 0; v < 7; v++) begin
         single_op(vecs[v].req, vecs[v].a, vecs[v].b, vecs[v].exp_y);
      end

      // both requesters held valid: alternating grants, one response per cycle
      for (int k = 0; k <= 13; k++) begin
         @(posedge clk); #1;
         if (k == 0) begin
            req_valid = 2'b11;
            set_op(0, 15, 7);
            set_op(1, 3, 2);
         end
         if (k == 10) req_valid = '0;
         @(negedge clk);
         check("rr_grant", int'(req_ready), (k < 10) ? (((k % 2) == 0) ? 1 : 2) : 0);
         if (k >= 3 && k <= 12) begin
            check("rr_rsp_valid", int'(rsp_valid), 1);
            check("rr_rsp_id", int'(rsp_id), (k - 3) % 2);
            check("rr_rsp_y", int'(rsp_y), (((k - 3) % 2) == 0) ? 105 : 6);
         end else begin
            check("rr_rsp_idle", int'(rsp_valid), 0);
         end
      end

      // backpressure: exactly RSP_DEPTH accepts, then drain and resume
      rsp_ready = 1'b0;
      for (int k = 0; k <= 13; k++) begin
         @(posedge clk); #1;
         if (k == 0) begin
            req_valid = 2'b01;
            set_op(0, 2, 3);
         end
         if (k == 8) rsp_ready = 1'b1;
         @(negedge clk);
         if (k < 8) check("bp_ready", int'(req_ready), (k < 4) ? 1 : 0);
         else       check("bp_resume", int'(req_ready), (k == 8) ? 0 : 1);
         if (k >= 3) begin
            check("bp_rsp_valid", int'(rsp_valid), 1);
            check("bp_rsp_y", int'(rsp_y), 6);
            check("bp_rsp_id", int'(rsp_id), 0);
         end
      end
      @(posedge clk); #1;
      req_valid = '0;
      cnt = 0;
      @(negedge clk);
      while (rsp_valid && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      check("bp_drained", int'(rsp_valid), 0);

      // reset with one result buffered and one in flight
      rsp_ready = 1'b0;
      for (int k = 0; k <= 3; k++) begin
         @(posedge clk); #1;
         if (k == 0) begin
            req_valid = 2'b11;
            set_op(0, 5, 5);
            set_op(1, 6, 6);
         end
         if (k == 2) req_valid = '0;
         @(negedge clk);
         if (k == 0) check("mr_grant0", int'(req_ready), 2);
         if (k == 1) check("mr_grant1", int'(req_ready), 1);
      end
      check("mr_pre_valid", int'(rsp_valid), 1);
      check("mr_pre_y", int'(rsp_y), 36);
      #2 rst = 1'b0;
      #1;
      check("mr_valid_now", int'(rsp_valid), 0);
      check("mr_y_now", int'(rsp_y), 0);
      check("mr_id_now", int'(rsp_id), 0);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      rsp_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         check("mr_no_stale", int'(rsp_valid), 0);
      end
      single_op(0, 4, 4, 16);

      // near-full FIFO with push and pop in the same cycle
      rsp_ready = 1'b0;
      for (int k = 0; k <= 10; k++) begin
         @(posedge clk); #1;
         if (k == 0) req_valid = 2'b10;
         if (k < 4) set_op(1, k + 1, 1);
         if (k == 4) req_valid = '0;
         if (k == 5) rsp_ready = 1'b1;
         @(negedge clk);
         if (k < 4) check("ff_ready", int'(req_ready), 2);
         if (k >= 3 && k <= 8) begin
            check("ff_rsp_valid", int'(rsp_valid), 1);
            check("ff_rsp_id", int'(rsp_id), 1);
            check("ff_rsp_y", int'(rsp_y), (k <= 5) ? 1 : k - 4);
         end else if (k >= 9) begin
            check("ff_no_dup", int'(rsp_valid), 0);
         end
      end

      // three requesters: 0,1,2 rotation, then req1 drops out
      set_op3(0, 1, 1);
      set_op3(1, 2, 2);
      set_op3(2, 3, 3);
      t_rsp_ready = 1'b1;
      for (int k = 0; k <= 13; k++) begin
         @(posedge clk); #1;
         if (k == 0)  t_valid = 3'b111;
         if (k == 6)  t_valid = 3'b101;
         if (k == 10) t_valid = 3'b000;
         @(negedge clk);
         check("n3_grant", int'(t_ready), (k < 10) ? (1 << gseq[k]) : 0);
         if (k >= 3 && k <= 12) begin
            check("n3_rsp_valid", int'(t_rsp_valid), 1);
            check("n3_rsp_id", int'(t_rsp_id), gseq[k-3]);
            check("n3_rsp_y", int'(t_rsp_y), (gseq[k-3] + 1) * (gseq[k-3] + 1));
         end else begin
            check("n3_rsp_idle", int'(t_rsp_valid), 0);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
